// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: round-robin CPU/DBG arbiter for a 64-word memory with sub-word load extension and SB/SH read-modify-write (ports: cpu_*, dbg_*, mem_*)
module dmem_access_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [2:0]  cpu_funct3_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,
  output logic        cpu_stall_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_ack_o,
  output logic        dbg_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, ACC, RMW_WR} state_e;
  state_e state_q, state_d;
  logic [31:0] addr_q, wdata_q, merged_q;
  logic [2:0] f3_q;
  logic we_q, dbg_q, last_q;
  logic gnt_dbg, bad, sub, ack, err;
  logic [31:0] rd, rdata, shifted, mask, ins;
  logic [4:0] sh;
  assign gnt_dbg = dbg_req_i & (~cpu_req_i | ~last_q);
  assign sh = {addr_q[1:0], 3'b000};
  assign shifted = mem_rdata_i >> sh;
  assign mask = (f3_q[0] ? 32'h0000_ffff : 32'h0000_00ff) << sh;
  assign ins = wdata_q << sh;
  assign sub = we_q & (f3_q != 3'b010);
  assign bad = (addr_q >= 32'(DEPTH * 4)) | (f3_q[1:0] == 2'b01 & addr_q[0]) |
               (f3_q[1:0] == 2'b10 & addr_q[1:0] != 2'b00) |
               (we_q ? f3_q > 3'b010 : (f3_q == 3'b011 | f3_q[2:1] == 2'b11));
  assign rd = f3_q[1] ? mem_rdata_i :
              f3_q[0] ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]} :
                        {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      last_q <= 1'b1;
      dbg_q <= 1'b0;
      addr_q <= '0;
      we_q <= 1'b0;
      f3_q <= '0;
      wdata_q <= '0;
      merged_q <= '0;
    end else begin
      if (state_q == IDLE && (cpu_req_i | dbg_req_i)) begin
        dbg_q <= gnt_dbg;
        last_q <= gnt_dbg;
        addr_q <= gnt_dbg ? dbg_addr_i : cpu_addr_i;
        we_q <= gnt_dbg ? dbg_we_i : cpu_we_i;
        f3_q <= gnt_dbg ? 3'b010 : cpu_funct3_i;
        wdata_q <= gnt_dbg ? dbg_wdata_i : cpu_wdata_i;
      end
      if (state_q == ACC) merged_q <= (mem_rdata_i & ~mask) | (ins & mask);
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? ((cpu_req_i | dbg_req_i) ? ACC : IDLE) :
              (state_q == ACC && !bad && sub) ? RMW_WR : IDLE;
  end
  always_comb begin
    ack = 1'b0;
    err = 1'b0;
    mem_re_o = 1'b0;
    mem_we_o = 1'b0;
    mem_wdata_o = '0;
    rdata = '0;
    if (reset_i && state_q == ACC) begin
      ack = bad | ~sub;
      err = bad;
      mem_re_o = ~bad & (~we_q | sub);
      mem_we_o = ~bad & we_q & ~sub;
      mem_wdata_o = (~bad & we_q & ~sub) ? wdata_q : '0;
      rdata = (~bad & ~we_q) ? rd : '0;
    end else if (reset_i && state_q == RMW_WR) begin
      ack = 1'b1;
      mem_we_o = 1'b1;
      mem_wdata_o = merged_q;
    end
    mem_addr_o = (mem_re_o | mem_we_o) ? 32'(addr_q[AW+1:2]) : '0;
  end
  assign cpu_ack_o = ack & ~dbg_q;
  assign dbg_ack_o = ack & dbg_q;
  assign cpu_err_o = err & ~dbg_q;
  assign dbg_err_o = err & dbg_q;
  assign cpu_rdata_o = dbg_q ? '0 : rdata;
  assign dbg_rdata_o = dbg_q ? rdata : '0;
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized and directed check of dmem_access_ctrl against a transaction-level reference model
module tb_dmem_access_ctrl;
  typedef struct packed {
    logic we;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;
  typedef struct packed {
    logic port;
    logic err;
    logic [31:0] rdata;
    logic [31:0] wd;
    logic [31:0] maddr;
    logic [31:0] lat;
  } log_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [2:0] cpu_funct3 = '0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic cpu_ack, cpu_err, cpu_stall;
  logic dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic [31:0] dbg_rdata;
  logic dbg_ack, dbg_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_we, mem_re;
  logic [31:0] mem [64];
  logic [31:0] init_val [64];
  logic [31:0] ref_mem [64];
  bit preload = 1'b1;
  op_t cpu_q[$], dbg_q[$];
  log_t acks[$];
  bit busy, cur_dbg, last_dbg = 1'b1, inject;
  int step, cyc, gcyc, rst_hold, cgap, dgap, gap_max;
  int n_chk, n_fail;
  op_t cur;
  dmem_access_ctrl dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_funct3_i(cpu_funct3),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
    .cpu_ack_o(cpu_ack), .cpu_err_o(cpu_err), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_rdata_o(dbg_rdata), .dbg_ack_o(dbg_ack),
    .dbg_err_o(dbg_err), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_rdata_i(mem_rdata)
  );
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val[i];
    end else if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  function automatic bit is_err(op_t o);
    bit ok;
    if (o.addr >= 32'd256) return 1'b1;
    ok = o.we ? (o.f3 <= 3'd2) : (o.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!ok) return 1'b1;
    if (o.f3[1:0] == 2'd1) return o.addr[0];
    if (o.f3[1:0] == 2'd2) return o.addr[1:0] != 2'd0;
    return 1'b0;
  endfunction
  function automatic logic [31:0] load_val(logic [31:0] w, op_t o);
    logic [31:0] s;
    s = w >> (8 * int'(o.addr[1:0]));
    case (o.f3)
      3'd0: return 32'($signed(s[7:0]));
      3'd1: return 32'($signed(s[15:0]));
      3'd4: return {24'd0, s[7:0]};
      3'd5: return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction
  function automatic logic [31:0] merge(logic [31:0] w, op_t o);
    logic [31:0] r;
    int b;
    r = w;
    b = 8 * int'(o.addr[1:0]);
    if (o.f3 == 3'd0) r[b +: 8] = o.wdata[7:0];
    else r[b +: 16] = o.wdata[15:0];
    return r;
  endfunction
  function automatic op_t rnd_op(bit d);
    op_t o;
    int x;
    o.we = 1'($urandom_range(0, 1));
    o.f3 = 3'($urandom_range(0, 7));
    if (d) o.f3 = 3'd2;
    else if ($urandom_range(0, 3) != 0) begin
      x = $urandom_range(0, 4);
      o.f3 = o.we ? 3'($urandom_range(0, 2)) : 3'(x > 2 ? x + 1 : x);
    end
    o.addr = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(256, 1023)) : 32'($urandom_range(0, 255));
    if ($urandom_range(0, 1) != 0) o.addr[0] = 1'b0;
    if ($urandom_range(0, 1) != 0 && o.f3[1:0] == 2'd2) o.addr[1] = 1'b0;
    o.wdata = $urandom;
    return o;
  endfunction
  task automatic drive();
    op_t h;
    reset = (rst_hold == 0);
    if (rst_hold > 0) rst_hold--;
    preload = 1'b0;
    cpu_req = (cgap == 0) && (cpu_q.size() != 0);
    if (cgap > 0) cgap--;
    if (cpu_req) begin
      h = cpu_q[0];
      cpu_we = h.we;
      cpu_funct3 = h.f3;
      cpu_addr = h.addr;
      cpu_wdata = h.wdata;
    end
    dbg_req = (dgap == 0) && (dbg_q.size() != 0);
    if (dgap > 0) dgap--;
    if (dbg_req) begin
      h = dbg_q[0];
      dbg_we = h.we;
      dbg_addr = h.addr;
      dbg_wdata = h.wdata;
    end
  endtask
  task automatic check_step();
    logic e_ack, e_err, e_re, e_we, wr;
    logic [31:0] e_addr, e_wd, e_rd;
    int idx;
    bit sub;
    log_t l;
    e_ack = 0; e_err = 0; e_re = 0; e_we = 0; wr = 0;
    e_addr = '0; e_wd = '0; e_rd = '0; idx = 0; sub = 0;
    if (busy) begin
      idx = int'(cur.addr[7:2]);
      sub = cur.we && cur.f3 != 3'd2;
      e_err = is_err(cur);
      if (step == 0 && e_err) e_ack = 1;
      else if (step == 0 && !cur.we) begin
        e_re = 1; e_ack = 1; e_rd = load_val(ref_mem[idx], cur);
      end else if (step == 0 && !sub) begin
        e_we = 1; e_ack = 1; e_wd = cur.wdata; wr = 1;
      end else if (step == 0) e_re = 1;
      else begin
        e_we = 1; e_ack = 1; e_wd = merge(ref_mem[idx], cur); wr = 1;
      end
      if (!e_err) e_addr = 32'(idx);
    end
    chk("cpu_ack", cpu_ack, e_ack & ~cur_dbg & busy);
    chk("dbg_ack", dbg_ack, e_ack & cur_dbg & busy);
    chk("cpu_err", cpu_err, e_err & e_ack & ~cur_dbg);
    chk("dbg_err", dbg_err, e_err & e_ack & cur_dbg);
    chk("mem_re", mem_re, e_re);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("cpu_stall", cpu_stall, cpu_req & ~(e_ack & ~cur_dbg & busy));
    if (e_we) chk("mem_wdata", mem_wdata, e_wd);
    if (!(e_ack && wr)) begin
      chk("cpu_rdata", cpu_rdata, (e_ack && !cur_dbg) ? e_rd : 32'd0);
      chk("dbg_rdata", dbg_rdata, (e_ack && cur_dbg) ? e_rd : 32'd0);
    end
    if (inject && busy && step == 1) begin
      reset = 1'b0;
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      inject = 0;
      if (cur_dbg) void'(dbg_q.pop_front()); else void'(cpu_q.pop_front());
      busy = 0;
      last_dbg = 1;
      return;
    end
    if (!reset) begin
      busy = 0;
      last_dbg = 1;
    end else if (busy) begin
      if (e_ack) begin
        l.port = cur_dbg;
        l.err = cur_dbg ? dbg_err : cpu_err;
        l.rdata = cur_dbg ? dbg_rdata : cpu_rdata;
        l.wd = mem_wdata;
        l.maddr = mem_addr;
        l.lat = 32'(cyc - gcyc);
        acks.push_back(l);
        if (wr) ref_mem[idx] = e_wd;
        if (cur_dbg) begin
          void'(dbg_q.pop_front());
          dgap = $urandom_range(0, gap_max);
        end else begin
          void'(cpu_q.pop_front());
          cgap = $urandom_range(0, gap_max);
        end
        busy = 0;
      end else step = 1;
    end else if (cpu_req || dbg_req) begin
      cur_dbg = (cpu_req && dbg_req) ? !last_dbg : dbg_req;
      cur = cur_dbg ? dbg_q[0] : cpu_q[0];
      last_dbg = cur_dbg;
      busy = 1;
      step = 0;
      gcyc = cyc;
    end
  endtask
  task automatic cycle();
    cyc++;
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_step();
  endtask
  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while ((cpu_q.size() != 0 || dbg_q.size() != 0 || busy) && n < maxc) begin
      cycle();
      n++;
    end
    if (n >= maxc) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d cycles without draining, required fewer", n);
      cpu_q.delete();
      dbg_q.delete();
    end
  endtask
  task automatic op1(input bit d, input bit we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] w, output log_t r);
    op_t o;
    o.we = we;
    o.f3 = d ? 3'd2 : f3;
    o.addr = a;
    o.wdata = w;
    acks.delete();
    if (d) dbg_q.push_back(o); else cpu_q.push_back(o);
    run_idle(50);
    r = (acks.size() != 0) ? acks[$] : '0;
  endtask
  initial begin
    log_t r;
    foreach (init_val[i]) begin
      init_val[i] = $urandom;
      ref_mem[i] = init_val[i];
    end
    rst_hold = 1;
    repeat (3) cycle();
    chk("reset_outputs", {31'd0, cpu_ack | dbg_ack | mem_we | mem_re | cpu_stall | (|mem_addr)}, 32'd0);
    op1(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, r);
    chk("sw_wdata", r.wd, 32'hDEADBEEF);
    chk("sw_addr", r.maddr, 32'd4);
    chk("sw_lat", r.lat, 32'd1);
    op1(0, 0, 3'd2, 32'h10, 32'h0, r);
    chk("lw_rdata", r.rdata, 32'hDEADBEEF);
    chk("lw_lat", r.lat, 32'd1);
    op1(1, 1, 3'd2, 32'h10, 32'h11223344, r);
    op1(0, 1, 3'd0, 32'h11, 32'h000000AA, r);
    chk("sb_merged", r.wd, 32'h1122AA44);
    chk("sb_addr", r.maddr, 32'd4);
    chk("sb_lat", r.lat, 32'd2);
    op1(0, 0, 3'd0, 32'h11, 32'h0, r);
    chk("lb_rdata", r.rdata, 32'hFFFFFFAA);
    op1(0, 0, 3'd4, 32'h11, 32'h0, r);
    chk("lbu_rdata", r.rdata, 32'h000000AA);
    op1(0, 0, 3'd1, 32'h12, 32'h0, r);
    chk("lh_rdata", r.rdata, 32'h00001122);
    op1(0, 0, 3'd1, 32'h13, 32'h0, r);
    chk("lh_misaligned_err", r.err, 32'd1);
    chk("lh_misaligned_rdata", r.rdata, 32'd0);
    op1(0, 0, 3'd2, 32'h100, 32'h0, r);
    chk("lw_range_err", r.err, 32'd1);
    op1(0, 0, 3'd3, 32'h10, 32'h0, r);
    chk("bad_funct3_err", r.err, 32'd1);
    op1(1, 0, 3'd2, 32'h10, 32'h0, r);
    chk("dbg_rdata_word", r.rdata, 32'h1122AA44);
    acks.delete();
    for (int i = 0; i < 4; i++) begin
      cpu_q.push_back(rnd_op(0));
      dbg_q.push_back(rnd_op(1));
    end
    run_idle(100);
    for (int i = 0; i < 8; i++) chk($sformatf("grant_%0d", i), (i < acks.size()) ? 32'(acks[i].port) : 32'hx, 32'(i % 2));
    op1(1, 1, 3'd2, 32'h20, 32'h55667788, r);
    acks.delete();
    inject = 1;
    cpu_q.push_back('{we: 1'b1, f3: 3'd1, addr: 32'h22, wdata: 32'h0000BEEF});
    run_idle(20);
    cycle();
    chk("post_reset_outputs", {31'd0, cpu_ack | dbg_ack | mem_we | mem_re | cpu_stall | (|mem_addr) | (|cpu_rdata)}, 32'd0);
    chk("rmw_abandoned_mem", mem[8], 32'h55667788);
    chk("rmw_abandoned_ack", 32'(acks.size()), 32'd0);
    cpu_q.push_back(rnd_op(0));
    dbg_q.push_back(rnd_op(1));
    run_idle(50);
    chk("post_reset_tie", (acks.size() != 0) ? 32'(acks[0].port) : 32'hx, 32'd0);
    gap_max = 3;
    for (int i = 0; i < 120; i++) begin
      cpu_q.push_back(rnd_op(0));
      dbg_q.push_back(rnd_op(1));
    end
    run_idle(4000);
    cycle();
    for (int i = 0; i < 64; i++) chk($sformatf("mem_%0d", i), mem[i], ref_mem[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencing and arbitration controller in front of the 64-word data memory of the RV32 core. It shares the memory between the pipeline MEM stage (CPU port) and a word-only debug/loader port (DBG port). It converts byte-addressed RV32I loads and stores into word-indexed memory accesses, performing read-modify-write for SB/SH and sign/zero extension for sub-word loads. It stalls the CPU port until its access completes.

## Interface
- DEPTH, 64, number of 32-bit memory words
- AW, 6, word-index width (log2 DEPTH)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low
- cpu_req  in  1  CPU access request; held with operands until cpu_ack
- cpu_we  in  1  1 = store, 0 = load
- cpu_funct3  in  3  RV32I load/store funct3
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data (low byte/half used for SB/SH)
- cpu_rdata  out  32  load result; valid only in the cpu_ack cycle, else 0
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  with cpu_ack: access rejected
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- dbg_req, dbg_we  in  1  debug request / write; same hold rule
- dbg_addr  in  32  byte address, word accesses only
- dbg_wdata  in  32  write data
- dbg_rdata  out  32  read word; valid only in the dbg_ack cycle, else 0
- dbg_ack, dbg_err  out  1  as for the CPU port
- mem_addr  out  32  word index, zero-extended
- mem_wdata  out  32  memory write data
- mem_we, mem_re  out  1  memory strobes
- mem_rdata  in  32  combinational memory read data

## Operation
- States: IDLE, ACC, RMW_WR.
- IDLE: no strobes.
  - If any req is high, pick a winner.
  - Latch the winner's addr/we/funct3/wdata and its identity.
  - Go to ACC.
- Arbitration is round-robin using a last_grant register, which resets to DBG, so the CPU wins the first tie. A lone requester always wins.
- Validity is checked in ACC:
  - addr ≥ DEPTH*4: error.
  - Halfword access with addr[0]=1: error.
  - Word access with addr[1:0]≠0: error.
  - CPU load funct3 ∉ {000,001,010,100,101}: error.
  - CPU store funct3 ∉ {000,001,010}: error.
  - DBG: always a word access.
- ACC actions:
  - Error: ack+err pulse, no strobes, go to IDLE.
  - Load: mem_re=1, mem_addr=addr[AW+1:2]. Extract byte lane addr[1:0] (little-endian, byte k = bits 8k+7:8k). LB/LH sign-extend; LBU/LHU zero-extend. Drive rdata, ack, go to IDLE.
  - SW (or DBG write): mem_we=1, mem_wdata=wdata, ack, go to IDLE.
  - SB/SH: mem_re=1. Register mem_rdata with the new byte/half merged into its lane. Go to RMW_WR.
- RMW_WR: mem_we=1, mem_wdata=merged word, same mem_addr, ack, go to IDLE.
- mem_addr is 0 whenever neither strobe is active.
- Dropping req before ack is illegal; behaviour in that case is unspecified.

## Timing
- Reset (reset=0 at an edge): state=IDLE, last_grant=DBG. Every output is 0 the following cycle.
- Request seen at edge N (state IDLE): ACC occupies cycle N+1.
  - Loads, word stores and errors: ack during N+1.
  - SB/SH: ack during N+2.
- After ack the FSM always passes through IDLE for one cycle. A requester that keeps req high with new operands is re-arbitrated at the end of that IDLE cycle. Peak throughput is 1 op per 2 cycles (3 for SB/SH).
- A pending requester is served after at most one op of the other port.
- Reset asserted while in RMW_WR (before the write edge): the write is abandoned and the memory word is unchanged.
- Reset mid-op: no ack is produced for the abandoned request.

## Test plan
- CPU SW addr 0x10, data 0xDEADBEEF, then LW 0x10 → mem_we=1 with mem_addr=4 in the ack cycle; LW cpu_rdata=0xDEADBEEF; each ack arrives 1 cycle after the grant edge.
- Word 4 = 0x11223344, CPU SB addr 0x11 data 0xAA → mem_re then mem_we with mem_wdata=0x1122AA44, ack on 2nd cycle. Follow-ups:
  - LB 0x11 → 0xFFFFFFAA.
  - LBU 0x11 → 0x000000AA.
  - LH 0x12 → 0x00001122.
- CPU LH addr 0x13; LW addr 0x100; load funct3=011 → each gives ack+err, no strobes, cpu_rdata=0.
- cpu_req and dbg_req held high continuously with new operands after each ack → grants CPU, DBG, CPU, DBG. cpu_stall is high in every non-ack cycle while cpu_req is high.
- SH addr 0x22 in progress, reset=0 in the RMW_WR cycle → no mem_we at that edge, word 8 unchanged, all outputs 0 the next cycle, first post-reset tie goes to the CPU.
